// File: rtl/ram_arb_pkg.sv
// Shared types and default widths for the data-RAM port arbiter.
package ram_arb_pkg;

    localparam int RAM_ARB_AW = 12;
    localparam int RAM_ARB_DW = 8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RD_WAIT,
        RD_DATA
    } arb_state_t;

    typedef enum logic {
        OWN_CPU,
        OWN_HOST
    } owner_t;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// CPU, host and RAM-side signals of the arbiter.
// slave = arbiter view, master = requesters plus RAM.
interface ram_port_arbiter_if
    import ram_arb_pkg::*;
#(
    parameter int AW = RAM_ARB_AW,
    parameter int DW = RAM_ARB_DW
);

    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ack;
    logic          cpu_rvalid;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_stall;

    logic          host_req;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_ack;
    logic          host_rvalid;
    logic [DW-1:0] host_rdata;

    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_data;
    logic          ram_wren;
    logic [DW-1:0] ram_q;

    logic          busy;

    modport slave (
        input  cpu_req, cpu_we,
        input  cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rvalid,
        output cpu_rdata, cpu_stall,
        input  host_req, host_we,
        input  host_addr, host_wdata,
        output host_ack, host_rvalid,
        output host_rdata,
        output ram_address, ram_data,
        output ram_wren,
        input  ram_q,
        output busy
    );

    modport master (
        output cpu_req, cpu_we,
        output cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rvalid,
        input  cpu_rdata, cpu_stall,
        output host_req, host_we,
        output host_addr, host_wdata,
        input  host_ack, host_rvalid,
        input  host_rdata,
        input  ram_address, ram_data,
        input  ram_wren,
        output ram_q,
        input  busy
    );

endinterface

// File: rtl/rr_arbiter_2.sv
// Two-way combinational arbiter, round-robin on contention.
// RAM_ARB_FIXED_PRIO_EN: CPU always wins contention.
module rr_arbiter_2
    import ram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  owner_t     last_owner,
    output owner_t     winner
);

    owner_t pick;

`ifdef RAM_ARB_FIXED_PRIO_EN
    assign pick = OWN_CPU;
`else
    assign pick = (last_owner == OWN_CPU)
                ? OWN_HOST : OWN_CPU;
`endif

    // bit 0 = CPU, bit 1 = host
    always_comb begin
        winner = OWN_CPU;
        unique case (1'b1)
            (req == 2'b10): winner = OWN_HOST;
            (req == 2'b11): winner = pick;
            default:        winner = OWN_CPU;
        endcase
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares the data RAM port between CPU and host.
// Build option: RAM_ARB_FIXED_PRIO_EN (CPU-priority arbitration).
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int AW = RAM_ARB_AW,
    parameter int DW = RAM_ARB_DW
)(
    input  logic               clk,
    input  logic               reset,
    ram_port_arbiter_if.slave  bus
);

    arb_state_t    state;
    owner_t        owner;
    owner_t        last_owner;
    owner_t        winner;
    logic [1:0]    req;
    logic          win_we;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_wdata;

    assign req = {bus.host_req, bus.cpu_req};

    rr_arbiter_2 u_arb (
        .req        (req),
        .last_owner (last_owner),
        .winner     (winner)
    );

    always_comb begin
        win_we    = bus.cpu_we;
        win_addr  = bus.cpu_addr;
        win_wdata = bus.cpu_wdata;
        if (winner == OWN_HOST) begin
            win_we    = bus.host_we;
            win_addr  = bus.host_addr;
            win_wdata = bus.host_wdata;
        end
    end

    assign bus.busy = (state != IDLE);

    // Freeze until the write is issued or read data returns.
    assign bus.cpu_stall = bus.cpu_req
                         & ~(bus.cpu_ack & bus.cpu_we)
                         & ~bus.cpu_rvalid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            owner           <= OWN_CPU;
            last_owner      <= OWN_HOST;
            bus.cpu_ack     <= 1'b0;
            bus.cpu_rvalid  <= 1'b0;
            bus.cpu_rdata   <= '0;
            bus.host_ack    <= 1'b0;
            bus.host_rvalid <= 1'b0;
            bus.host_rdata  <= '0;
            bus.ram_address <= '0;
            bus.ram_data    <= '0;
            bus.ram_wren    <= 1'b0;
        end else begin
            bus.cpu_ack     <= 1'b0;
            bus.cpu_rvalid  <= 1'b0;
            bus.host_ack    <= 1'b0;
            bus.host_rvalid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (|req) begin
                        owner           <= winner;
                        last_owner      <= winner;
                        bus.ram_address <= win_addr;
                        bus.ram_data    <= win_wdata;
                        bus.ram_wren    <= win_we;
                        bus.cpu_ack     <= (winner == OWN_CPU);
                        bus.host_ack    <= (winner == OWN_HOST);
                        state           <= ISSUE;
                    end
                end
                ISSUE: begin
                    bus.ram_wren <= 1'b0;
                    state <= bus.ram_wren ? IDLE : RD_WAIT;
                end
                RD_WAIT: begin
                    if (owner == OWN_HOST) begin
                        bus.host_rdata  <= bus.ram_q;
                        bus.host_rvalid <= 1'b1;
                    end else begin
                        bus.cpu_rdata  <= bus.ram_q;
                        bus.cpu_rvalid <= 1'b1;
                    end
                    state <= RD_DATA;
                end
                RD_DATA: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a cycle-level reference model.
module tb_ram_port_arbiter;

    localparam int AW = 12;
    localparam int DW = 8;

`ifdef RAM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ram_port_arbiter_if #(.AW(AW), .DW(DW)) bus();

    ram_port_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    // Synchronous RAM: q is valid the cycle after address capture.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    initial for (int i = 0; i < (1<<AW); i++) mem[i] = '0;
    always @(posedge clk) begin
        if (bus.ram_wren) mem[bus.ram_address] <= bus.ram_data;
        bus.ram_q <= mem[bus.ram_address];
    end

    // Reference model: m_cyc counts cycles since the grant edge.
    logic [DW-1:0] m_mem [0:(1<<AW)-1];
    initial for (int i = 0; i < (1<<AW); i++) m_mem[i] = '0;
    int            m_cyc;
    bit            m_own, m_last, m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data, m_cr, m_hr;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_cyc = 0; m_own = 0; m_last = 1; m_we = 0;
            m_addr = '0; m_data = '0; m_cr = '0; m_hr = '0;
        end else if (m_cyc == 0) begin
            if (bus.cpu_req || bus.host_req) begin
                if (bus.cpu_req && bus.host_req)
                    m_own = FIXED ? 1'b0 : ~m_last;
                else
                    m_own = bus.host_req;
                m_last = m_own;
                m_we   = m_own ? bus.host_we : bus.cpu_we;
                m_addr = m_own ? bus.host_addr : bus.cpu_addr;
                m_data = m_own ? bus.host_wdata : bus.cpu_wdata;
                m_cyc  = 1;
            end
        end else begin
            if (m_cyc == 1 && m_we) m_mem[m_addr] = m_data;
            if (m_cyc == 2) begin
                if (m_own) m_hr = m_mem[m_addr];
                else       m_cr = m_mem[m_addr];
            end
            m_cyc++;
            if (m_cyc > (m_we ? 1 : 3)) m_cyc = 0;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            logic eac, eah, erc, erh, est;
            eac = (m_cyc == 1) && !m_own;
            eah = (m_cyc == 1) && m_own;
            erc = (m_cyc == 3) && !m_own;
            erh = (m_cyc == 3) && m_own;
            est = bus.cpu_req & ~(eac & bus.cpu_we) & ~erc;
            chk("cpu_ack", bus.cpu_ack, eac);
            chk("host_ack", bus.host_ack, eah);
            chk("cpu_rvalid", bus.cpu_rvalid, erc);
            chk("host_rvalid", bus.host_rvalid, erh);
            chk("cpu_rdata", bus.cpu_rdata, m_cr);
            chk("host_rdata", bus.host_rdata, m_hr);
            chk("ram_wren", bus.ram_wren, (m_cyc == 1) && m_we);
            chk("ram_address", bus.ram_address, m_addr);
            chk("ram_data", bus.ram_data, m_data);
            chk("busy", bus.busy, m_cyc != 0);
            chk("cpu_stall", bus.cpu_stall, est);
            chk("pulse_excl",
                32'(bus.cpu_ack) + 32'(bus.host_ack) +
                32'(bus.cpu_rvalid) + 32'(bus.host_rvalid) <= 1, 1);
        end
    end

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic access(input bit host, input bit we,
                          input logic [AW-1:0] a,
                          input logic [DW-1:0] d,
                          output int ack_n, output int rv_n,
                          output int wren_n,
                          output logic [DW-1:0] rd,
                          output logic st);
        int n;
        bit done;
        ack_n = -1; rv_n = -1; wren_n = 0;
        rd = '0; st = 1'bx; n = 0; done = 0;
        step();
        if (host) begin
            bus.host_req = 1; bus.host_we = we;
            bus.host_addr = a; bus.host_wdata = d;
        end else begin
            bus.cpu_req = 1; bus.cpu_we = we;
            bus.cpu_addr = a; bus.cpu_wdata = d;
        end
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
            if (bus.ram_wren) wren_n++;
            if (host ? bus.host_ack : bus.cpu_ack) ack_n = n;
            if (host ? bus.host_rvalid : bus.cpu_rvalid) begin
                rv_n = n;
                rd = host ? bus.host_rdata : bus.cpu_rdata;
            end
            done = we ? (ack_n > 0) : (rv_n > 0);
            if (done) st = bus.cpu_stall;
        end
        if (!done) chk("access_timeout", 0, 1);
        step();
        if (host) bus.host_req = 0;
        else      bus.cpu_req = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t", $time);
        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures + 1);
        $fatal(1);
    end

    initial begin
        int an, rn, wn, n, hv, ca, cv;
        logic [DW-1:0] rd, hd, cd;
        logic st;
        bit gr[$];
        bit exp_g[4];

        bus.cpu_req = 0; bus.cpu_we = 0;
        bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.host_req = 0; bus.host_we = 0;
        bus.host_addr = '0; bus.host_wdata = '0;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_wren", bus.ram_wren, 0);
        chk("rst_addr", bus.ram_address, 0);
        chk("rst_cpu_ack", bus.cpu_ack, 0);
        chk("rst_host_rvalid", bus.host_rvalid, 0);
        chk("rst_cpu_rdata", bus.cpu_rdata, 0);
        cmp_en = 1;

        // Contention straight out of reset, both held.
        step();
        reset = 0;
        bus.cpu_req = 1; bus.cpu_we = 1;
        bus.cpu_addr = 12'h100; bus.cpu_wdata = 8'h11;
        bus.host_req = 1; bus.host_we = 1;
        bus.host_addr = 12'h200; bus.host_wdata = 8'h22;
        n = 0;
        while (gr.size() < 4 && n < 40) begin
            @(negedge clk);
            n++;
            if (bus.cpu_ack) gr.push_back(1'b0);
            if (bus.host_ack) gr.push_back(1'b1);
        end
        #2;
        bus.cpu_req = 0;
        bus.host_req = 0;
        chk("grant_count", gr.size(), 4);
        exp_g = FIXED ? '{0, 0, 0, 0} : '{0, 1, 0, 1};
        for (int i = 0; i < 4 && i < gr.size(); i++)
            chk($sformatf("grant_%0d", i), gr[i], exp_g[i]);
        repeat (3) step();

        reset = 1;
        step();
        reset = 0;

        // CPU write then read.
        access(0, 1, 12'h010, 8'hA5, an, rn, wn, rd, st);
        chk("cw_ack_lat", an, 1);
        chk("cw_wren_cycles", wn, 1);
        chk("cw_stall_ack", st, 0);
        access(0, 0, 12'h010, 8'h00, an, rn, wn, rd, st);
        chk("cr_ack_lat", an, 1);
        chk("cr_rv_lat", rn, 3);
        chk("cr_rdata", rd, 8'hA5);
        chk("cr_stall_rv", st, 0);

        // Host preload of the top word, CPU readback.
        access(1, 1, 12'hFFF, 8'h3C, an, rn, wn, rd, st);
        chk("hw_ack_lat", an, 1);
        access(0, 0, 12'hFFF, 8'h00, an, rn, wn, rd, st);
        chk("cr_top_rdata", rd, 8'h3C);
        chk("cr_top_rv_lat", rn, 3);

        // CPU raises a read while the host read is in flight.
        step();
        bus.host_req = 1; bus.host_we = 0;
        bus.host_addr = 12'hFFF;
        n = 0; hv = -1; ca = -1; cv = -1;
        hd = '0; cd = '0;
        while (cv < 0 && n < 30) begin
            @(negedge clk);
            n++;
            if (bus.host_rvalid) begin
                hv = n; hd = bus.host_rdata;
                chk("stall_host_rv", bus.cpu_stall, 1);
            end
            if (bus.cpu_ack) ca = n;
            if (bus.cpu_rvalid) begin
                cv = n; cd = bus.cpu_rdata;
            end
            #2;
            if (n == 1) begin
                bus.cpu_req = 1; bus.cpu_we = 0;
                bus.cpu_addr = 12'h010;
            end
            if (hv > 0 && n == hv + 1) bus.host_req = 0;
        end
        if (cv < 0) chk("stall_timeout", 0, 1);
        step();
        bus.cpu_req = 0;
        chk("st_host_rv", hv, 3);
        chk("st_cpu_ack", ca, 5);
        chk("st_cpu_rv", cv, 7);
        chk("st_host_rdata", hd, 8'h3C);
        chk("st_cpu_rdata", cd, 8'hA5);
        repeat (2) step();

        // Reset while a write is being issued.
        step();
        bus.cpu_req = 1; bus.cpu_we = 1;
        bus.cpu_addr = 12'h020; bus.cpu_wdata = 8'h77;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.cpu_ack && n < 10);
        chk("mid_wren_pre", bus.ram_wren, 1);
        #2;
        reset = 1;
        #1;
        chk("mid_wren", bus.ram_wren, 0);
        chk("mid_busy", bus.busy, 0);
        chk("mid_cpu_ack", bus.cpu_ack, 0);
        chk("mid_host_ack", bus.host_ack, 0);
        chk("mid_rvalid", bus.cpu_rvalid | bus.host_rvalid, 0);
        chk("mid_addr", bus.ram_address, 0);
        chk("mid_cpu_rdata", bus.cpu_rdata, 0);
        bus.cpu_req = 0;
        repeat (2) step();
        reset = 0;
        access(0, 0, 12'h020, 8'h00, an, rn, wn, rd, st);
        chk("aborted_write", rd, 8'h00);
        access(1, 0, 12'h010, 8'h00, an, rn, wn, rd, st);
        chk("hr_rv_lat", rn, 3);
        chk("hr_rdata", rd, 8'hA5);
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
